// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state encodings and phase-index width helper.
package phase_sequencer_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Index width is never below one bit so a two-phase build still has a usable phase port.
    function automatic int phase_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_next_sel.sv
// Rotating-priority search for the next non-skipped phase after the current one.
module phase_next_sel
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int IDX_W      = phase_idx_w(NUM_PHASES)
) (
    input  logic [IDX_W-1:0]      cur_i,
    input  logic [NUM_PHASES-1:0] skip_i,
    input  logic                  start_i,
    output logic [IDX_W-1:0]      nxt_o,
    output logic                  wrap_o,
    output logic                  none_o
);

    int                 base_s;
    logic [IDX_W-1:0]   cand_s;
    logic               hit_s;
    logic               found_s;

    // From idle the search starts at index 0; otherwise at cur+1 with cur itself visited last.
    always_comb begin
        nxt_o   = '0;
        found_s = 1'b0;
        base_s  = 0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            base_s  = start_i ? k : (int'(cur_i) + 1 + k);
            base_s  = (base_s >= NUM_PHASES) ? (base_s - NUM_PHASES) : base_s;
            cand_s  = IDX_W'(base_s);
            hit_s   = !found_s && !skip_i[cand_s];
            nxt_o   = hit_s ? cand_s : nxt_o;
            found_s = found_s | hit_s;
        end
        wrap_o = start_i ? 1'b0 : (nxt_o <= cur_i);
        none_o = ~found_s;
    end

endmodule

// File: rtl/phase_sequencer.sv
// Round-robin phase enable sequencer with skip mask, frame-boundary stop and frame counter.
// Optional per-phase watchdog is built only when PHASE_WATCHDOG_EN is defined.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES  = 3,
    parameter int FRAME_W     = 8,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   run_i,
    input  logic [NUM_PHASES-1:0]                  skip_i,
    input  logic [NUM_PHASES-1:0]                  done_i,
    output logic [NUM_PHASES-1:0]                  en_o,
    output logic [phase_idx_w(NUM_PHASES)-1:0]     phase_o,
    output logic                                   busy_o,
    output logic                                   frame_tick_o,
    output logic [FRAME_W-1:0]                     frame_cnt_o,
    output logic                                   timeout_o,
    output logic                                   wd_err_o
);

    localparam int IDX_W = phase_idx_w(NUM_PHASES);
    localparam logic [NUM_PHASES-1:0] EN_LSB = {{(NUM_PHASES-1){1'b0}}, 1'b1};

    logic                  state_q, state_d;
    logic [IDX_W-1:0]      phase_q, phase_d;
    logic [NUM_PHASES-1:0] en_q, en_d;
    logic                  tick_q, tick_d;
    logic [FRAME_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]      nxt_s;
    logic                  wrap_s;
    logic                  none_s;
    logic                  start_s;
    logic                  done_hit_s;
    logic                  timeout_hit_s;
    logic                  advance_s;

    phase_next_sel #(
        .NUM_PHASES (NUM_PHASES),
        .IDX_W      (IDX_W)
    ) u_next_sel (
        .cur_i   (phase_q),
        .skip_i  (skip_i),
        .start_i (start_s),
        .nxt_o   (nxt_s),
        .wrap_o  (wrap_s),
        .none_o  (none_s)
    );

    // Only the active phase's done bit can advance the sequence.
    always_comb begin
        start_s    = (state_q == ST_IDLE);
        done_hit_s = (state_q == ST_RUN) && done_i[phase_q];
        advance_s  = done_hit_s | timeout_hit_s;
    end

`ifdef PHASE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            wd_err_q, wd_err_d;

    // A done on the limit cycle wins over the watchdog, so no timeout is flagged then.
    always_comb begin
        timeout_hit_s = (state_q == ST_RUN) && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) && !done_hit_s;
        wd_cnt_d      = ((state_q == ST_RUN) && !advance_s) ? (wd_cnt_q + WD_W'(1'b1)) : '0;
        timeout_d     = timeout_hit_s;
        wd_err_d      = wd_err_q | timeout_hit_s;
    end

    // Watchdog registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
            wd_err_q  <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
            wd_err_q  <= wd_err_d;
        end
    end

    assign timeout_o = timeout_q;
    assign wd_err_o  = wd_err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_o     = 1'b0;
    assign wd_err_o      = 1'b0;
`endif

    // Sequencing FSM: a frame ends on any advance that does not move to a higher index.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        en_d    = en_q;
        tick_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i && !none_s) begin
                    state_d = ST_RUN;
                    phase_d = nxt_s;
                    en_d    = EN_LSB << nxt_s;
                end else begin
                    phase_d = '0;
                    en_d    = '0;
                end
            end
            ST_RUN: begin
                if (!advance_s) begin
                    state_d = ST_RUN;
                end else if (none_s) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    en_d    = '0;
                end else begin
                    tick_d = wrap_s;
                    cnt_d  = wrap_s ? (cnt_q + FRAME_W'(1'b1)) : cnt_q;
                    if (wrap_s && !run_i) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                        en_d    = '0;
                    end else begin
                        phase_d = nxt_s;
                        en_d    = EN_LSB << nxt_s;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                en_d    = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            en_q    <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en_o         = en_q;
    assign phase_o      = phase_q;
    assign busy_o       = (state_q == ST_RUN);
    assign frame_tick_o = tick_q;
    assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer (3 phases, 8-bit frame counter, 16-cycle watchdog limit).
module tb_phase_sequencer;

    logic       clk_i;
    logic       reset_i;
    logic       run_i;
    logic [2:0] skip_i;
    logic [2:0] done_i;
    logic [2:0] en_o;
    logic [1:0] phase_o;
    logic       busy_o;
    logic       frame_tick_o;
    logic [7:0] frame_cnt_o;
    logic       timeout_o;
    logic       wd_err_o;

    typedef struct packed {
        logic [2:0] en;
        logic [1:0] ph;
        logic       busy;
        logic       tick;
        logic [7:0] cnt;
        logic       tmo;
        logic       wd;
    } obs_t;

    obs_t       exp_q[$];
    int         total;
    int         bad;
    logic [7:0] exp_cnt;
    logic       exp_wd;

    phase_sequencer #(
        .NUM_PHASES  (3),
        .FRAME_W     (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .run_i        (run_i),
        .skip_i       (skip_i),
        .done_i       (done_i),
        .en_o         (en_o),
        .phase_o      (phase_o),
        .busy_o       (busy_o),
        .frame_tick_o (frame_tick_o),
        .frame_cnt_o  (frame_cnt_o),
        .timeout_o    (timeout_o),
        .wd_err_o     (wd_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [1:0] oh2idx(input logic [2:0] e);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (e[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {en_o, phase_o, busy_o, frame_tick_o, frame_cnt_o, timeout_o, wd_err_o};
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got en=%b ph=%0d busy=%b tick=%b cnt=%0d tmo=%b wd=%b, want en=%b ph=%0d busy=%b tick=%b cnt=%0d tmo=%b wd=%b",
                     name, $time, act.en, act.ph, act.busy, act.tick, act.cnt, act.tmo, act.wd,
                     exp.en, exp.ph, exp.busy, exp.tick, exp.cnt, exp.tmo, exp.wd);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic [2:0] sk, input logic [2:0] dn,
                        input logic [2:0] en, input logic tk, input logic tmo);
        obs_t e;
        @(negedge clk_i);
        reset_i = 1'b0;
        run_i   = r;
        skip_i  = sk;
        done_i  = dn;
        if (tk)  exp_cnt = exp_cnt + 8'd1;
        if (tmo) exp_wd  = 1'b1;
        e = {en, oh2idx(en), |en, tk, exp_cnt, tmo, exp_wd};
        exp_q.push_back(e);
    endtask

    task automatic rst_cycle();
        @(negedge clk_i);
        reset_i = 1'b1;
        run_i   = 1'b0;
        skip_i  = 3'b000;
        done_i  = 3'b000;
        exp_cnt = 8'd0;
        exp_wd  = 1'b0;
        exp_q.push_back('0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation just after each rising edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("cycle", sample(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = 8'd0;
        exp_wd  = 1'b0;
        reset_i = 1'b1;
        run_i   = 1'b0;
        skip_i  = 3'b000;
        done_i  = 3'b000;
        #1;
        compare("reset_state", sample(), '0);
        rst_cycle();
        rst_cycle();

        // Basic frame: enable one cycle after run, then 010, 100, 001 with a tick.
        step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b001, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b010, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b100, 3'b001, 1'b1, 1'b0);
        step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);

        // Skip phase 1.
        step(1'b1, 3'b010, 3'b001, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b010, 3'b100, 3'b001, 1'b1, 1'b0);

        // run_i dropped mid-frame: phase 2 still runs, then idle at frame end.
        step(1'b1, 3'b000, 3'b001, 3'b010, 1'b0, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0);
        step(1'b0, 3'b000, 3'b010, 3'b100, 1'b0, 1'b0);
        step(1'b0, 3'b000, 3'b100, 3'b000, 1'b1, 1'b0);
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

        // Done noise on inactive bits is ignored.
        step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b110, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b110, 3'b001, 1'b0, 1'b0);

        // Held done re-advances every cycle.
        step(1'b1, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b111, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b111, 3'b001, 1'b1, 1'b0);

        // Skipping the active phase does not abort it.
        step(1'b1, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b001, 3'b001, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b010, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b100, 3'b001, 1'b1, 1'b0);

        // All skipped at an advance: idle without a tick; start blocked while all skipped.
        step(1'b1, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0);
        step(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0);

        // Start picks lowest non-skipped; a lone eligible phase ends a frame on each done.
        step(1'b1, 3'b011, 3'b000, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b011, 3'b100, 3'b100, 1'b1, 1'b0);
        step(1'b1, 3'b000, 3'b100, 3'b001, 1'b1, 1'b0);

        // 256 frames: counter passes 255 -> 0 and returns to its starting value.
        for (int f = 0; f < 256; f++) begin
            step(1'b1, 3'b000, 3'b001, 3'b010, 1'b0, 1'b0);
            step(1'b1, 3'b000, 3'b010, 3'b100, 1'b0, 1'b0);
            step(1'b1, 3'b000, 3'b100, 3'b001, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-phase: outputs clear before the next rising edge.
        step(1'b1, 3'b000, 3'b001, 3'b010, 1'b0, 1'b0);
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        run_i   = 1'b0;
        done_i  = 3'b000;
        exp_cnt = 8'd0;
        exp_wd  = 1'b0;
        #1;
        compare("async_reset", sample(), '0);
        exp_q.push_back('0);
        rst_cycle();
        step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);

`ifdef PHASE_WATCHDOG_EN
        // Withheld done: forced advance on the 16th edge after phase entry.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
        end
        step(1'b1, 3'b000, 3'b000, 3'b010, 1'b0, 1'b1);
        step(1'b1, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b010, 3'b100, 1'b0, 1'b0);
        rst_cycle();
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
`else
        // Without the watchdog a withheld done holds the phase indefinitely.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
        end
        step(1'b1, 3'b000, 3'b001, 3'b010, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() > 0) @(negedge clk_i);
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed three-phase enable/done scheduler in the game top level (input, action, display).
- Drives NUM_PHASES one-hot enable strobes in round-robin order. Each phase advances on its own done pulse.
- Supports per-phase skip, graceful stop at a frame boundary, a frame counter, and an optional per-phase watchdog.
- Sits between the top level and the phase sub-blocks, replacing the hand-coded case FSM.

Parameters:
- NUM_PHASES, 3: number of phases; legal range 2..16.
- FRAME_W, 8: frame counter width.
- TIMEOUT_CYC, 1048576: watchdog limit in cycles per phase; only used with PHASE_WATCHDOG_EN; must be at least 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous active-high reset.
- run_i  in  1  level: 1 = sequence frames, 0 = stop at next frame end.
- skip_i  in  NUM_PHASES  bit p = 1 excludes phase p; sampled only when selecting the next phase.
- done_i  in  NUM_PHASES  bit p = phase p finished; only the active phase's bit is honoured.
- en_o  out  NUM_PHASES  one-hot enable of the active phase, registered; all-zero when idle.
- phase_o  out  max(1,$clog2(NUM_PHASES))  index of the active phase; 0 when idle.
- busy_o  out  1  1 while state is RUN.
- frame_tick_o  out  1  one-cycle pulse when the last active phase of a frame completes.
- frame_cnt_o  out  FRAME_W  completed frames; wraps modulo 2^FRAME_W.
- timeout_o  out  1  one-cycle pulse on a forced advance.
- wd_err_o  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset is asynchronous and takes effect immediately, including mid-phase. No frame_tick_o is generated by a reset.
- States are IDLE and RUN.
- IDLE -> RUN: on an edge with run_i=1 and at least one skip_i bit clear.
  - Selects the lowest-index non-skipped phase.
  - en_o and phase_o are valid the cycle after run_i is sampled high (latency 1).
- Advancing in RUN, with active phase p:
  - An edge with done_i[p]=1 clears en_o[p] and sets the enable of the next phase on the same edge (zero idle gap).
  - The next phase is the first non-skipped index after p, wrapping from NUM_PHASES-1 to 0. The search starts at p+1; p itself is eligible last.
- Frame end: an advance whose next index is not greater than p (a wrap, or p was the only eligible phase).
  - frame_tick_o pulses for 1 cycle and frame_cnt_o increments.
  - If run_i=0 on that edge, go to IDLE, en_o=0 and phase_o=0; the tick and increment still occur.
- If all skip_i bits are set at an advance, go to IDLE with no frame tick.
- done_i on inactive bits is ignored. A done_i held high re-advances on every cycle; sub-blocks must pulse it.
- run_i deassertion mid-frame does not stop the sequence until the frame ends.
- skip_i changes never abort the current phase.
- Exactly one en_o bit is set in RUN; none in IDLE.

Optional Feature:
- Macro: PHASE_WATCHDOG_EN.
- With the macro defined:
  - A per-phase cycle counter clears on every phase entry.
  - When it reaches TIMEOUT_CYC-1 with no done_i[p], the block advances exactly as for a done.
  - On a forced advance, timeout_o pulses for 1 cycle and wd_err_o is set until reset.
  - If done_i[p] and the timeout coincide, the cycle is treated as a normal done: no timeout_o.
- Without the macro: no counter is built; timeout_o and wd_err_o are tied to 0.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE=1'b0, ST_RUN=1'b1);
  - the phase-index width function.
- One sub-module, phase_next_sel: combinational rotate-priority search.
  - Inputs: current index, skip mask, start flag.
  - Outputs: next index, wrap flag, none-eligible flag.

Test Plan:
- Reset, then run_i=1 with skip_i=0 and NUM_PHASES=3.
  - Required: en_o=001 one cycle later.
  - Pulse done_i[0], [1], [2] in turn. Required: en_o goes 010, 100, 001; frame_tick_o pulses once; frame_cnt_o=1.
- skip_i=010, full frame.
  - Required: en_o sequence 001 -> 100 -> 001, with the tick on the 100 -> 001 advance.
- Drop run_i=0 while en_o=010.
  - Required: phase 2 still runs; on done_i[2], frame_cnt_o increments and en_o=000, busy_o=0.
- Noise on inactive done bits, then wrap.
  - Assert done_i=110 while en_o=001. Required: no change.
  - Run 256 frames with FRAME_W=8. Required: frame_cnt_o wraps 255 -> 0.
- Assert reset_i asynchronously mid-phase.
  - Required: all outputs 0 before the next clock edge; restart begins at phase 0.
- Watchdog, with PHASE_WATCHDOG_EN and TIMEOUT_CYC=16.
  - Withhold done_i[0]. Required: forced advance 16 cycles after phase entry, timeout_o pulses once, wd_err_o=1 until reset.
